// File: rtl/irq_pkg.sv
// Shared types and default sizing for the prioritised interrupt controller.
package irq_pkg;

  localparam int NBUS_DEF = 3;
  localparam int NCH_DEF  = 9;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder; used for both bus and channel selection.
module prio_enc #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  in_vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_irq_ctrl.sv
// Multi-bus interrupt controller: sticky pending bits, fixed bus/channel priority,
// and a registered grant presented on a valid/ready interface.
module prio_irq_ctrl
  import irq_pkg::*;
#(
  parameter int NBUS = NBUS_DEF,
  parameter int NCH  = NCH_DEF,
  parameter int BW   = (NBUS > 1) ? $clog2(NBUS) : 1,
  parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBUS*NCH-1:0]  req,
  input  logic [NCH-1:0]       chan_en,
  output logic                 irq_valid,
  input  logic                 irq_ready,
  output logic [BW-1:0]        irq_bus,
  output logic [CW-1:0]        irq_chan,
  output logic [NCH-1:0]       irq_vec,
  output logic [NBUS*NCH-1:0]  pend,
  output irq_state_e           dbg_state
);

  localparam int NB = NBUS * NCH;

  // Handshake: a grant transfers on any edge where irq_valid && irq_ready.
  // Once irq_valid is high the grant fields are frozen until that transfer;
  // irq_ready is ignored while irq_valid is low.

  irq_state_e      state_q, state_d;
  logic [NB-1:0]   pend_q, pend_d;
  logic [NB-1:0]   en_rep, elig, gmask, arb_vec;
  logic [NBUS-1:0] bus_any;
  logic [BW-1:0]   win_bus;
  logic            bus_found;
  logic [NCH-1:0]  row;
  logic [CW-1:0]   win_chan;
  logic            chan_found;
  logic            win_found;
  logic            hs, load, clear;

  always_comb begin
    en_rep = '0;
    for (int b = 0; b < NBUS; b++) en_rep[b*NCH +: NCH] = chan_en;
  end

  // One-hot mask of the grant currently presented.
  always_comb begin
    gmask = '0;
    for (int b = 0; b < NBUS; b++)
      for (int c = 0; c < NCH; c++)
        if (irq_bus == BW'(b) && irq_chan == CW'(c)) gmask[b*NCH + c] = 1'b1;
  end

  assign elig = pend_q & en_rep;
  assign hs   = (state_q == ST_PRESENT) && irq_ready;

  // While presenting, the outgoing grant must not be picked again this cycle,
  // even if a same-cycle re-request keeps its pending bit set.
  assign arb_vec = (state_q == ST_PRESENT) ? (elig & ~gmask) : elig;

  always_comb begin
    bus_any = '0;
    for (int b = 0; b < NBUS; b++) bus_any[b] = |arb_vec[b*NCH +: NCH];
  end

  prio_enc #(.W(NBUS), .IW(BW)) u_bus_enc (
    .in_vec (bus_any),
    .idx    (win_bus),
    .found  (bus_found)
  );

  always_comb begin
    row = '0;
    for (int b = 0; b < NBUS; b++)
      if (win_bus == BW'(b)) row = arb_vec[b*NCH +: NCH];
  end

  prio_enc #(.W(NCH), .IW(CW)) u_chan_enc (
    .in_vec (row),
    .idx    (win_chan),
    .found  (chan_found)
  );

  assign win_found = bus_found && chan_found;

  // Set beats clear when the granted bit is re-requested in the handshake cycle.
  assign pend_d = (pend_q & ~(hs ? gmask : '0)) | (req & en_rep);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_PRESENT;
          load    = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (hs) begin
          if (win_found) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            clear   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      irq_bus  <= '0;
      irq_chan <= '0;
      irq_vec  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (load) begin
        irq_bus  <= win_bus;
        irq_chan <= win_chan;
        irq_vec  <= NCH'(1) << win_chan;
      end else if (clear) begin
        irq_bus  <= '0;
        irq_chan <= '0;
        irq_vec  <= '0;
      end
    end
  end

  assign irq_valid = (state_q == ST_PRESENT);
  assign pend      = pend_q;
  assign dbg_state = state_q;

endmodule
